scale_row_sched: RTL and testbench

Row scheduler for the video scaler's line-buffer path. For each destination row it works out which source rows the vertical interpolator needs, from the 2.8 fixed-point vertical scale factor. It requests source-row transfers from the RAM/FIFO line-buffer controller with a `wr_req`/`tran_done` handshake until those rows are resident. It then streams the destination row's column indices to the interpolation datapath and advances through the frame.

---
 rtl/scale_row_sched.sv | 123 ++++++++++++
 tb/tb_scale_row_sched.sv | 258 +++++++++++++++++++++++++
 2 files changed

// File: rtl/scale_row_sched.sv
// Vertical row scheduler: loads source rows until the interpolator's pair is resident, then streams columns.
// Optional stall counter output is enabled with `define SCALE_SCHED_STALL_CNT_EN.
module scale_row_sched #(
  parameter int DST_W = 200,
  parameter int DST_H = 150,
  parameter int SRC_H = 480
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        frame_start,
  input  logic [9:0]  y_scale,
  input  logic        tran_done,
  input  logic        col_ready,
  output logic        wr_req,
  output logic [10:0] dst_row,
  output logic [10:0] src_top,
  output logic [7:0]  y_frac,
  output logic        row_start,
  output logic        col_valid,
  output logic [10:0] col_idx,
  output logic        frame_done,
  output logic        busy
`ifdef SCALE_SCHED_STALL_CNT_EN
  ,
  output logic [15:0] stall_cnt
`endif
);

  typedef enum logic [2:0] {IDLE, CHECK, LOAD, EMIT, NEXT, DONE} state_t;

  state_t      state, state_nxt;
  logic [18:0] acc;
  logic [9:0]  step;
  logic [10:0] src_loaded;
  logic [10:0] row_q;
  logic [10:0] col_q;
  logic        row_start_q;

  logic [11:0] need_raw, need;
  logic        load_more;
  logic        last_col;
  logic [10:0] row_inc;

  // Interpolator needs rows top and top+1; clamp at the last source row.
  assign need_raw  = {1'b0, acc[18:8]} + 12'd1;
  assign need      = (need_raw > 12'(SRC_H - 1)) ? 12'(SRC_H - 1) : need_raw;
  assign load_more = ({1'b0, src_loaded} <= need);
  assign last_col  = (col_q == 11'(DST_W - 1));
  assign row_inc   = row_q + 11'd1;

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      IDLE:    if (frame_start) state_nxt = CHECK;
      CHECK:   state_nxt = load_more ? LOAD : EMIT;
      LOAD:    if (tran_done) state_nxt = CHECK;
      EMIT:    if (col_ready && last_col) state_nxt = NEXT;
      NEXT:    state_nxt = (row_inc == 11'(DST_H)) ? DONE : CHECK;
      DONE:    state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_comb begin
    wr_req     = (state == LOAD);
    col_valid  = (state == EMIT);
    frame_done = (state == DONE);
    busy       = (state != IDLE);
    row_start  = row_start_q;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      acc         <= '0;
      step        <= '0;
      src_loaded  <= '0;
      row_q       <= '0;
      col_q       <= '0;
      row_start_q <= 1'b0;
    end else begin
      row_start_q <= (state == CHECK) && !load_more;
      case (state)
        IDLE: if (frame_start) begin
          step       <= (y_scale == 10'd0) ? 10'h100 : y_scale;
          acc        <= '0;
          src_loaded <= '0;
          row_q      <= '0;
          col_q      <= '0;
        end
        LOAD: if (tran_done) src_loaded <= src_loaded + 11'd1;
        EMIT: if (col_ready) col_q <= last_col ? 11'd0 : col_q + 11'd1;
        NEXT: begin
          acc   <= acc + 19'(step);
          row_q <= row_inc;
          col_q <= '0;
        end
        default: ;
      endcase
    end
  end

  assign dst_row = row_q;
  assign col_idx = col_q;
  assign src_top = acc[18:8];
  assign y_frac  = acc[7:0];

`ifdef SCALE_SCHED_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (rst)
      stall_cnt <= '0;
    else if (state == IDLE && frame_start)
      stall_cnt <= '0;
    else if (((state == EMIT && !col_ready) || state == LOAD) && stall_cnt != 16'hFFFF)
      stall_cnt <= stall_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_scale_row_sched.sv
// Bench for scale_row_sched: drives frames, records per-row behaviour, compares to a row-level model.
module tb_scale_row_sched;
  localparam int DST_W = 8;
  localparam int DST_H = 4;
  localparam int SRC_H = 6;

  logic        clk = 1'b0;
  logic        rst, frame_start, tran_done, col_ready;
  logic [9:0]  y_scale;
  logic        wr_req, row_start, col_valid, frame_done, busy;
  logic [10:0] dst_row, src_top, col_idx;
  logic [7:0]  y_frac;
`ifdef SCALE_SCHED_STALL_CNT_EN
  logic [15:0] stall_cnt;
`endif

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  scale_row_sched #(.DST_W(DST_W), .DST_H(DST_H), .SRC_H(SRC_H)) dut (
    .clk(clk), .rst(rst), .frame_start(frame_start), .y_scale(y_scale),
    .tran_done(tran_done), .col_ready(col_ready), .wr_req(wr_req),
    .dst_row(dst_row), .src_top(src_top), .y_frac(y_frac), .row_start(row_start),
    .col_valid(col_valid), .col_idx(col_idx), .frame_done(frame_done), .busy(busy)
`ifdef SCALE_SCHED_STALL_CNT_EN
    , .stall_cnt(stall_cnt)
`endif
  );

  // Expected per-row results
  int exp_top[8], exp_frac[8], exp_loads[8];
  // Observations from the last frame
  int obs_rows, obs_dst[8], obs_top[8], obs_frac[8], obs_loads[8];
  int obs_xfers[8], obs_cycles[8], obs_idx_bad[8], obs_unstable[8];
  int obs_done_cnt, obs_done_lat, obs_first_wr, obs_drop_bad, obs_rs_bad;
  int obs_total_xfer, obs_stall, obs_post_bad, obs_timeout, obs_aborted;

  // Row r sits at r*step; rows top and top+1 must be resident, never beyond the source height.
  task automatic model(input logic [9:0] ys);
    int step, loaded, pos, want;
    step   = (ys == 10'd0) ? 256 : int'(ys);
    loaded = 0;
    for (int r = 0; r < DST_H; r++) begin
      pos          = r * step;
      exp_top[r]   = pos / 256;
      exp_frac[r]  = pos % 256;
      want         = (exp_top[r] + 2 < SRC_H) ? exp_top[r] + 2 : SRC_H;
      exp_loads[r] = (want > loaded) ? want - loaded : 0;
      if (want > loaded) loaded = want;
    end
  endtask

  // mode 0: ready always, 1: ready toggles 1/0 per row cycle, 2: random ready.
  task automatic run_frame(input logic [9:0] ys, input int mode, input int dly,
                           input bit spurious, input int abort_row);
    int cyc, wr_age, pend, row_cyc, xfer, last_xfer_cyc, r;
    bit rdy, td, td_acc;
    for (int i = 0; i < 8; i++) begin
      obs_dst[i] = -1; obs_top[i] = -1; obs_frac[i] = -1; obs_loads[i] = -1;
      obs_xfers[i] = 0; obs_cycles[i] = 0; obs_idx_bad[i] = 0; obs_unstable[i] = 0;
    end
    obs_rows = 0; obs_done_cnt = 0; obs_done_lat = -1; obs_first_wr = -1;
    obs_drop_bad = 0; obs_rs_bad = 0; obs_total_xfer = 0; obs_stall = 0;
    obs_post_bad = 0; obs_timeout = 0; obs_aborted = 0;
    cyc = 0; wr_age = 0; pend = 0; row_cyc = 0; xfer = 0; last_xfer_cyc = 0; td_acc = 0;
    y_scale = ys; frame_start = 1'b1; tran_done = 1'b0; col_ready = 1'b1;
    while (1) begin
      @(posedge clk); #1;
      cyc++;
      frame_start = 1'b0;
      if (td_acc && wr_req) obs_drop_bad++;
      if (wr_req && obs_first_wr < 0) obs_first_wr = cyc;
      if (row_start) begin
        if (!col_valid) obs_rs_bad++;
        if (obs_rows < 8) begin
          obs_dst[obs_rows] = dst_row; obs_top[obs_rows] = src_top;
          obs_frac[obs_rows] = y_frac; obs_loads[obs_rows] = pend;
        end
        obs_rows++; pend = 0; row_cyc = 0; xfer = 0;
      end
      if (frame_done) begin
        obs_done_cnt++;
        obs_done_lat = cyc - last_xfer_cyc;
      end
      if (abort_row >= 0 && col_valid && dst_row == 11'(abort_row) && row_cyc == 3) begin
        rst = 1'b1; tran_done = 1'b0; col_ready = 1'b1;
        @(posedge clk); #1;
        rst = 1'b0; obs_aborted = 1;
        return;
      end
      case (mode)
        0:       rdy = 1'b1;
        1:       rdy = col_valid ? (row_cyc % 2 == 0) : 1'b1;
        default: rdy = 1'($urandom_range(0, 1));
      endcase
      if (col_valid) begin
        if (obs_rows == 0) obs_rs_bad++;
        else if (obs_rows <= 8) begin
          r = obs_rows - 1;
          obs_cycles[r]++;
          if (col_idx !== 11'(xfer)) obs_idx_bad[r]++;
          if (src_top !== 11'(obs_top[r]) || y_frac !== 8'(obs_frac[r]) || dst_row !== 11'(obs_dst[r]))
            obs_unstable[r]++;
          if (rdy) begin xfer++; obs_xfers[r]++; obs_total_xfer++; last_xfer_cyc = cyc; end
        end
        if (!rdy) obs_stall++;
        row_cyc++;
      end
      if (wr_req) begin obs_stall++; wr_age++; end
      else wr_age = 0;
      td_acc = wr_req && (wr_age == dly);
      if (td_acc) pend++;
      td = td_acc;
      if (spurious && col_valid && $urandom_range(0, 2) == 0) td = 1'b1;
      if (spurious && wr_req && wr_age == 1) frame_start = 1'b1;
      tran_done = td; col_ready = rdy;
      if (frame_done) begin
        tran_done = 1'b0; col_ready = 1'b1;
        repeat (3) begin
          @(posedge clk); #1;
          if (busy || frame_done) obs_post_bad++;
        end
        return;
      end
      if (cyc > 3000) begin obs_timeout = 1; tran_done = 1'b0; return; end
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; frame_start = 1'b0; tran_done = 1'b0; col_ready = 1'b0; y_scale = '0;
    repeat (2) @(posedge clk); #1;
    checks++;
    if ({wr_req, dst_row, src_top, y_frac, row_start, col_valid, col_idx, frame_done, busy} !== '0) begin
      errors++; $display("FAIL reset_outputs got %h want 0",
        {wr_req, dst_row, src_top, y_frac, row_start, col_valid, col_idx, frame_done, busy});
    end
`ifdef SCALE_SCHED_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'd0) begin errors++; $display("FAIL reset_stall got %0d want 0", stall_cnt); end
`endif
    rst = 1'b0;
  endtask

  task automatic test_scale_1p5();
    model(10'h180); run_frame(10'h180, 0, 3, 1'b0, -1);
    checks++; if (obs_timeout !== 0 || obs_rows !== DST_H) begin errors++;
      $display("FAIL s15_rows got %0d want %0d timeout=%0d", obs_rows, DST_H, obs_timeout); end
    for (int r = 0; r < DST_H; r++) begin
      checks++; if (obs_dst[r] !== r || obs_top[r] !== exp_top[r] || obs_frac[r] !== exp_frac[r]) begin errors++;
        $display("FAIL s15_pos row%0d got dst=%0d top=%0d frac=%0d want %0d/%0d/%0d", r, obs_dst[r], obs_top[r], obs_frac[r], r, exp_top[r], exp_frac[r]); end
      checks++; if (obs_loads[r] !== exp_loads[r]) begin errors++;
        $display("FAIL s15_loads row%0d got %0d want %0d", r, obs_loads[r], exp_loads[r]); end
      checks++; if (obs_xfers[r] !== DST_W || obs_cycles[r] !== DST_W || obs_idx_bad[r] !== 0 || obs_unstable[r] !== 0) begin errors++;
        $display("FAIL s15_emit row%0d got xfers=%0d cycles=%0d idx_bad=%0d unstable=%0d want %0d/%0d/0/0", r, obs_xfers[r], obs_cycles[r], obs_idx_bad[r], obs_unstable[r], DST_W, DST_W); end
    end
    checks++; if (obs_first_wr !== 2) begin errors++; $display("FAIL s15_first_wr got %0d want 2", obs_first_wr); end
    checks++; if (obs_done_cnt !== 1 || obs_done_lat !== 2 || obs_total_xfer !== 32 || obs_post_bad !== 0) begin errors++;
      $display("FAIL s15_done got cnt=%0d lat=%0d xfers=%0d post=%0d want 1/2/32/0", obs_done_cnt, obs_done_lat, obs_total_xfer, obs_post_bad); end
    checks++; if (obs_drop_bad !== 0 || obs_rs_bad !== 0) begin errors++;
      $display("FAIL s15_handshake got drop_bad=%0d rs_bad=%0d want 0/0", obs_drop_bad, obs_rs_bad); end
  endtask

  task automatic test_zero_scale();
    model(10'h000); run_frame(10'h000, 0, 2, 1'b0, -1);
    checks++; if (obs_rows !== DST_H || obs_done_cnt !== 1) begin errors++;
      $display("FAIL zero_rows got rows=%0d done=%0d want %0d/1", obs_rows, obs_done_cnt, DST_H); end
    for (int r = 0; r < DST_H; r++) begin
      checks++; if (obs_top[r] !== r || obs_frac[r] !== 0 || obs_loads[r] !== exp_loads[r]) begin errors++;
        $display("FAIL zero_row row%0d got top=%0d frac=%0d loads=%0d want %0d/0/%0d", r, obs_top[r], obs_frac[r], obs_loads[r], r, exp_loads[r]); end
    end
  endtask

  task automatic test_ready_toggle();
    model(10'h180); run_frame(10'h180, 1, 3, 1'b0, -1);
    checks++; if (obs_rows !== DST_H || obs_done_cnt !== 1) begin errors++;
      $display("FAIL toggle_rows got rows=%0d done=%0d want %0d/1", obs_rows, obs_done_cnt, DST_H); end
    for (int r = 0; r < DST_H; r++) begin
      checks++; if (obs_xfers[r] !== DST_W || obs_cycles[r] !== 2 * DST_W - 1 || obs_idx_bad[r] !== 0) begin errors++;
        $display("FAIL toggle_row row%0d got xfers=%0d cycles=%0d idx_bad=%0d want %0d/%0d/0", r, obs_xfers[r], obs_cycles[r], obs_idx_bad[r], DST_W, 2 * DST_W - 1); end
    end
`ifdef SCALE_SCHED_STALL_CNT_EN
    checks++; if (stall_cnt !== 16'(obs_stall)) begin errors++; $display("FAIL toggle_stall got %0d want %0d", stall_cnt, obs_stall); end
`endif
  endtask

  task automatic test_ignored_events();
    model(10'h180); run_frame(10'h180, 0, 2, 1'b1, -1);
    checks++; if (obs_rows !== DST_H || obs_done_cnt !== 1 || obs_post_bad !== 0) begin errors++;
      $display("FAIL ignore_rows got rows=%0d done=%0d post=%0d want %0d/1/0", obs_rows, obs_done_cnt, obs_post_bad, DST_H); end
    for (int r = 0; r < DST_H; r++) begin
      checks++; if (obs_dst[r] !== r || obs_top[r] !== exp_top[r] || obs_loads[r] !== exp_loads[r] || obs_xfers[r] !== DST_W) begin errors++;
        $display("FAIL ignore_row row%0d got dst=%0d top=%0d loads=%0d xfers=%0d want %0d/%0d/%0d/%0d", r, obs_dst[r], obs_top[r], obs_loads[r], obs_xfers[r], r, exp_top[r], exp_loads[r], DST_W); end
    end
  endtask

  task automatic test_src_cap();
    int total;
    model(10'h300); run_frame(10'h300, 0, 3, 1'b0, -1);
    total = 0;
    for (int r = 0; r < DST_H; r++) begin
      total += obs_loads[r];
      checks++; if (obs_top[r] !== exp_top[r] || obs_loads[r] !== exp_loads[r]) begin errors++;
        $display("FAIL cap_row row%0d got top=%0d loads=%0d want %0d/%0d", r, obs_top[r], obs_loads[r], exp_top[r], exp_loads[r]); end
    end
    checks++; if (total !== SRC_H || obs_loads[DST_H-1] !== 0 || obs_done_cnt !== 1) begin errors++;
      $display("FAIL cap_total got loads=%0d last=%0d done=%0d want %0d/0/1", total, obs_loads[DST_H-1], obs_done_cnt, SRC_H); end
  endtask

  task automatic test_random();
    logic [9:0] ys;
    for (int f = 0; f < 6; f++) begin
      ys = 10'($urandom_range(0, 1023));
      model(ys); run_frame(ys, 2, int'($urandom_range(1, 5)), 1'($urandom_range(0, 1)), -1);
      checks++; if (obs_rows !== DST_H || obs_done_cnt !== 1 || obs_done_lat !== 2 || obs_drop_bad !== 0) begin errors++;
        $display("FAIL rand_frame ys=%h got rows=%0d done=%0d lat=%0d drop=%0d want %0d/1/2/0", ys, obs_rows, obs_done_cnt, obs_done_lat, obs_drop_bad, DST_H); end
      for (int r = 0; r < DST_H; r++) begin
        checks++; if (obs_top[r] !== exp_top[r] || obs_frac[r] !== exp_frac[r] || obs_loads[r] !== exp_loads[r]
                      || obs_xfers[r] !== DST_W || obs_idx_bad[r] !== 0 || obs_unstable[r] !== 0) begin errors++;
          $display("FAIL rand_row ys=%h row%0d got top=%0d frac=%0d loads=%0d xfers=%0d idx_bad=%0d want %0d/%0d/%0d/%0d/0", ys, r, obs_top[r], obs_frac[r], obs_loads[r], obs_xfers[r], obs_idx_bad[r], exp_top[r], exp_frac[r], exp_loads[r], DST_W); end
      end
`ifdef SCALE_SCHED_STALL_CNT_EN
      checks++; if (stall_cnt !== 16'(obs_stall)) begin errors++; $display("FAIL rand_stall got %0d want %0d", stall_cnt, obs_stall); end
`endif
    end
  endtask

  task automatic test_mid_reset();
    int bad;
    run_frame(10'h180, 0, 3, 1'b0, 2);
    checks++; if (obs_aborted !== 1) begin errors++; $display("FAIL mrst_reach got %0d want 1", obs_aborted); end
    checks++;
    if ({wr_req, dst_row, src_top, y_frac, row_start, col_valid, col_idx, frame_done, busy} !== '0) begin
      errors++; $display("FAIL mrst_outputs got %h want 0",
        {wr_req, dst_row, src_top, y_frac, row_start, col_valid, col_idx, frame_done, busy});
    end
    bad = 0;
    repeat (4) begin @(posedge clk); #1; if (busy || frame_done) bad++; end
    checks++; if (bad !== 0) begin errors++; $display("FAIL mrst_idle got %0d busy cycles want 0", bad); end
    model(10'h180); run_frame(10'h180, 0, 3, 1'b0, -1);
    checks++; if (obs_rows !== DST_H || obs_dst[0] !== 0 || obs_top[0] !== 0 || obs_loads[0] !== exp_loads[0] || obs_done_cnt !== 1) begin errors++;
      $display("FAIL mrst_restart got rows=%0d dst0=%0d top0=%0d loads0=%0d done=%0d want %0d/0/0/%0d/1", obs_rows, obs_dst[0], obs_top[0], obs_loads[0], obs_done_cnt, DST_H, exp_loads[0]); end
  endtask

  initial begin
    test_reset();
    test_scale_1p5();
    test_zero_scale();
    test_ready_toggle();
    test_ignored_events();
    test_src_cap();
    test_random();
    test_mid_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
